seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 29 ++
 rtl/seq_divider_sub_stage.sv | 34 +++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and FSM state encoding.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encoding 2'd3 is unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake plus operand and result buses of the divider.
// The sequencer (master) drives the request and operands; the divider
// (slave) returns status and results.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_sub_stage.sv
// Trial-subtraction stage: T = A - {1'b0, M} in WIDTH+1 bits, built as a
// ripple of full-adder cells adding the inverted divisor with carry-in 1.
// o_neg is the sign of T: high means the subtraction borrowed.
module seq_divider_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_t,
  output logic             o_neg
);

  logic [WIDTH:0] w_m_inv;
  logic [WIDTH:0] w_carry;

  assign w_m_inv    = ~{1'b0, i_m};
  assign w_carry[0] = 1'b1;

  // The carry out of the top cell is not needed: the sign bit carries the borrow.
  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_fa
      assign o_t[gi] = i_a[gi] ^ w_m_inv[gi] ^ w_carry[gi];
      if (gi < WIDTH) begin : g_carry
        assign w_carry[gi+1] = (i_a[gi] & w_m_inv[gi]) |
                               (w_carry[gi] & (i_a[gi] ^ w_m_inv[gi]));
      end
    end
  endgenerate

  assign o_neg = o_t[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned shift-and-subtract, one quotient
// bit per clock. Start pulse in, one-cycle done pulse out. A zero divisor
// skips the computation and reports all-ones quotient, dividend remainder.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         Clock,
  input  logic         Resetn,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH:0]   w_shift_a;
  logic [WIDTH:0]   w_t;
  logic             w_t_neg;
  logic             w_restore;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;

  // Requests are only honoured when no division is in flight.
  assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_zero_div = (bus.divisor == '0);
  assign w_last     = (r_count == CW'(1));

  // {A,Q} shifted left by one: the next dividend bit enters A.
  assign w_shift_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};

  seq_divider_sub_stage #(.WIDTH(WIDTH)) u_sub_stage (
    .i_a   (w_shift_a),
    .i_m   (r_m),
    .o_t   (w_t),
    .o_neg (w_t_neg)
  );

  // A partial remainder that had overflowed into A's top bit would always
  // exceed M, so that case never restores even if the truncated trial borrows.
  assign w_restore = w_t_neg & ~r_a[WIDTH];
  assign w_a_next  = w_restore ? w_shift_a : w_t;
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_restore};

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_accept) begin
          w_state_next = w_zero_div ? DONE : CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one restoring step per CALC cycle,
  // results latched on the last step and held until the next result.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_a     <= '0;
        r_q     <= bus.dividend;
        r_m     <= bus.divisor;
        r_count <= CW'(WIDTH);
        r_dbz   <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_a     <= w_a_next;
      r_q     <= w_q_next;
      r_count <= r_count - CW'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_a_next[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = (r_state == CALC);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): reset state, single ops,
// back-to-back ops, divide by zero, start ignored while busy, reset
// mid-calculation, and an exhaustive 16x16 operand sweep.
module tb_seq_divider;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   lat;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, checking busy on every cycle before it; c0 is the number
  // of cycles already elapsed since the accepting edge.
  task automatic wait_done(input string tag, input int c0, output int l);
    l = c0;
    while (!bus.done && l < 20) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      step();
      l++;
    end
    chk({tag, " done_seen"}, 32'(bus.done), 32'd1);
  endtask

  // Issue one operation from the current cycle and check the result on done.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er,
                        input logic edbz, input int elat);
    int l;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start = 1'b0;
    wait_done(tag, 1, l);
    chk({tag, " latency"}, 32'(l), 32'(elat));
    chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, " dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d",
             tag, a, b, bus.quotient, bus.remainder, bus.div_by_zero, l);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    step();
    step();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset quotient", 32'(bus.quotient), 32'd0);
    chk("reset remainder", 32'(bus.remainder), 32'd0);
    chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    step();

    // 13/4 = 3 r1, then results held in IDLE with done low
    run_op("13/4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 5);
    step();
    chk("13/4 done pulse width", 32'(bus.done), 32'd0);
    chk("13/4 held quotient", 32'(bus.quotient), 32'd3);
    chk("13/4 held remainder", 32'(bus.remainder), 32'd1);

    // Back-to-back: second start issued during the DONE cycle of the first
    run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);
    run_op("5/7 b2b", 4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 5);
    step();
    chk("5/7 done low after", 32'(bus.done), 32'd0);
    chk("5/7 busy low after", 32'(bus.busy), 32'd0);
    chk("5/7 held remainder", 32'(bus.remainder), 32'd5);

    // Divide by zero, held through IDLE, then cleared by a valid op
    run_op("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1);
    step();
    chk("9/0 held dbz", 32'(bus.div_by_zero), 32'd1);
    chk("9/0 held quotient", 32'(bus.quotient), 32'hF);
    run_op("8/2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5);
    step();

    // Start pulsed with new operands mid-CALC is ignored
    bus.start    = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    step();
    bus.start = 1'b0;
    step();
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd1;
    step();
    bus.start = 1'b0;
    wait_done("14/3 glitch", 3, lat);
    chk("14/3 glitch latency", 32'(lat), 32'd5);
    chk("14/3 glitch quotient", 32'(bus.quotient), 32'd4);
    chk("14/3 glitch remainder", 32'(bus.remainder), 32'd2);
    $display("op 14/3 glitch: q=%0d r=%0d latency=%0d", bus.quotient, bus.remainder, lat);
    step();
    chk("14/3 single done a", 32'(bus.done), 32'd0);
    step();
    chk("14/3 single done b", 32'(bus.done), 32'd0);

    // Reset two cycles into 11/2: outputs clear at once, no done follows
    bus.start    = 1'b1;
    bus.dividend = 4'd11;
    bus.divisor  = 4'd2;
    step();
    bus.start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset quotient", 32'(bus.quotient), 32'd0);
    chk("midreset remainder", 32'(bus.remainder), 32'd0);
    chk("midreset dbz", 32'(bus.div_by_zero), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midreset no done", 32'(bus.done), 32'd0);
      chk("midreset no busy", 32'(bus.busy), 32'd0);
    end
    $display("op 11/2 aborted by reset: outputs cleared, no done");
    run_op("11/2", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5);
    step();

    // Exhaustive sweep against hand arithmetic
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          run_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1);
        end else begin
          run_op($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5);
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
